// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head word is visible combinationally on popData.
// Define FIFO_ERROR_FLAGS_EN to add sticky overflow/underflow outputs.
module sync_fifo #(
  parameter int nrOfEntries = 16,
  parameter int bitWidth    = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                push,
  input  logic                pop,
  input  logic [bitWidth-1:0] pushData,
  output logic [bitWidth-1:0] popData,
  output logic                full,
`ifdef FIFO_ERROR_FLAGS_EN
  output logic                overflow,
  output logic                underflow,
`endif
  output logic                empty
);

  localparam int PW = $clog2(nrOfEntries);
  localparam int CW = PW + 1;

  logic [bitWidth-1:0] mem_q [nrOfEntries];
  logic [bitWidth-1:0] mem_d [nrOfEntries];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                push_acc, pop_acc;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(nrOfEntries));
  assign popData = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    // A full FIFO still takes a push when the same-cycle pop frees a slot.
    push_acc = push & (~full | pop);
    pop_acc  = pop & ~empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_acc) begin
      mem_d[wr_ptr_q] = pushData;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop_acc)
      rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left out of reset; empty masks stale contents.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

`ifdef FIFO_ERROR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q | (push & full & ~pop);
    underflow_d = underflow_q | (pop & empty);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed + scoreboarded random bench for sync_fifo (depth 16, 32-bit words).
module tb_sync_fifo;

  localparam int N = 16;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         push, pop;
  logic [W-1:0] pushData;
  logic [W-1:0] popData;
  logic         full, empty;
`ifdef FIFO_ERROR_FLAGS_EN
  logic         overflow, underflow;
`endif

  int checks   = 0;
  int failures = 0;

  sync_fifo #(.nrOfEntries(N), .bitWidth(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .pushData (pushData),
    .popData  (popData),
    .full     (full),
`ifdef FIFO_ERROR_FLAGS_EN
    .overflow (overflow),
    .underflow(underflow),
`endif
    .empty    (empty)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic ps, input logic pp, input logic [W-1:0] d);
    push     = ps;
    pop      = pp;
    pushData = d;
    cyc();
    push = 1'b0;
    pop  = 1'b0;
  endtask

  logic [W-1:0] model [$];
  logic         ps_r, pp_r, acc_push, acc_pop;
  logic [W-1:0] d_r;

  initial begin
    reset = 1'b0; push = 1'b0; pop = 1'b0; pushData = '0;
    cyc(); cyc();
    chk("rst_empty", W'(empty), 1);
    chk("rst_full", W'(full), 0);
    chk("rst_popdata", popData, 0);
    reset = 1'b1;
    cyc();

    // Fill / drain
    for (int i = 1; i <= N; i++) begin
      drive(1'b1, 1'b0, W'(i));
      if (i == 1) chk("fwft_first", popData, 1);
      if (i == N - 1) chk("full_at_15", W'(full), 0);
    end
    chk("full_at_16", W'(full), 1);
    chk("full_not_empty", W'(empty), 0);

    // Overflow: rejected push leaves contents intact
    drive(1'b1, 1'b0, 32'hDEADBEEF);
    chk("ovf_full", W'(full), 1);
    chk("ovf_head", popData, 1);
`ifdef FIFO_ERROR_FLAGS_EN
    chk("ovf_flag", W'(overflow), 1);
    chk("ovf_no_udf", W'(underflow), 0);
`endif

    for (int i = 1; i <= N; i++) begin
      chk($sformatf("drain_%0d", i), popData, W'(i));
      drive(1'b0, 1'b1, '0);
      if (i == 1) chk("drain_not_full", W'(full), 0);
    end
    chk("drain_empty", W'(empty), 1);
    chk("drain_popdata0", popData, 0);

    // Underflow: pop on empty is ignored
    drive(1'b0, 1'b1, '0);
    chk("udf_empty", W'(empty), 1);
    chk("udf_popdata", popData, 0);
`ifdef FIFO_ERROR_FLAGS_EN
    chk("udf_flag", W'(underflow), 1);
`endif
    drive(1'b1, 1'b0, 32'hA5A5A5A5);
    chk("after_udf_data", popData, 32'hA5A5A5A5);
    chk("after_udf_nempty", W'(empty), 0);
    drive(1'b0, 1'b1, '0);
    chk("after_udf_drain", W'(empty), 1);

    // Push+pop while full
    for (int i = 0; i < N; i++) drive(1'b1, 1'b0, W'(32'h100 + i));
    drive(1'b1, 1'b1, 32'h11);
    chk("pp_full_full", W'(full), 1);
    chk("pp_full_head", popData, 32'h101);
    for (int i = 1; i < N; i++) begin
      chk($sformatf("pp_seq_%0d", i), popData, W'(32'h100 + i));
      drive(1'b0, 1'b1, '0);
    end
    chk("pp_full_tail", popData, 32'h11);
    drive(1'b0, 1'b1, '0);
    chk("pp_full_drained", W'(empty), 1);

    // Push+pop while empty
    drive(1'b1, 1'b1, 32'h22);
    chk("pp_empty_data", popData, 32'h22);
    chk("pp_empty_nempty", W'(empty), 0);
    chk("pp_empty_nfull", W'(full), 0);
    drive(1'b0, 1'b1, '0);
    chk("pp_empty_cnt1", W'(empty), 1);

    // Asynchronous reset mid-operation with 5 words stored
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, W'(32'h50 + i));
    chk("mid_pre_nempty", W'(empty), 0);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_empty", W'(empty), 1);
    chk("mid_rst_popdata", popData, 0);
    chk("mid_rst_full", W'(full), 0);
`ifdef FIFO_ERROR_FLAGS_EN
    chk("mid_rst_ovf", W'(overflow), 0);
    chk("mid_rst_udf", W'(underflow), 0);
`endif
    cyc();
    reset = 1'b1;
    cyc();
    drive(1'b1, 1'b0, 32'h77);
    chk("post_rst_head", popData, 32'h77);
    drive(1'b0, 1'b1, '0);

    // Random wrap-around stress against a queue model
    for (int c = 0; c < 1000; c++) begin
      ps_r = 1'($urandom_range(0, 1));
      pp_r = 1'($urandom_range(0, 1));
      d_r  = $urandom;
      chk("rnd_empty", W'(empty), W'(model.size() == 0));
      chk("rnd_full", W'(full), W'(model.size() == N));
      chk("rnd_data", popData, (model.size() == 0) ? '0 : model[0]);
      acc_pop  = pp_r && (model.size() > 0);
      acc_push = ps_r && ((model.size() < N) || pp_r);
      drive(ps_r, pp_r, d_r);
      if (acc_pop)  void'(model.pop_front());
      if (acc_push) model.push_back(d_r);
    end
    chk("rnd_end_empty", W'(empty), W'(model.size() == 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock, first-word-fall-through FIFO buffer of nrOfEntries words, each bitWidth bits wide.
- Decouples a producer (push side) from a consumer (pop side) in the same clock domain.
- Provides full/empty status and combinational visibility of the head word.

Parameters:
- nrOfEntries, 16, FIFO depth in words; must be a power of two and at least 2.
- bitWidth, 32, width of each data word in bits.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  reset, asynchronous, active-low.
- push  input  1  write request; pushData is stored at the rising edge when accepted.
- pop  input  1  read request; the head word is discarded at the rising edge when accepted.
- pushData  input  bitWidth  data word to enqueue.
- popData  output  bitWidth  current head word (first-word-fall-through); 0 when empty.
- full  output  1  high when nrOfEntries words are stored.
- empty  output  1  high when no words are stored.

Behaviour:
- Storage: array of nrOfEntries x bitWidth registers.
- Pointers: write pointer and read pointer, log2(nrOfEntries) bits each, wrapping naturally modulo nrOfEntries.
- Occupancy: a count register, log2(nrOfEntries)+1 bits wide, range 0..nrOfEntries.
- Reset (reset=0, asynchronous): pointers=0, count=0, empty=1, full=0, popData=0. Storage contents are not cleared.
- Release of reset is synchronised by the user; the first accepted operation happens at the first rising edge with reset=1.
- Accepted push = push & (~full | pop). A push while full is accepted only if a pop is accepted in the same cycle.
- Accepted pop = pop & ~empty. A pop while empty is ignored, with no state change.
- On an accepted push: mem[wrPtr] <= pushData; wrPtr += 1.
- On an accepted pop: rdPtr += 1.
- Count update:
  - +1 on push only;
  - -1 on pop only;
  - unchanged when both are accepted or neither is.
- Simultaneous push+pop while empty: only the push is accepted; count becomes 1.
- Simultaneous push+pop while full: both are accepted; count stays nrOfEntries; the oldest word is removed and the new word is written into the freed slot.
- Flags are combinational from count: empty = (count==0); full = (count==nrOfEntries). Both update in the cycle after the edge that changes count.
- popData = empty ? 0 : mem[rdPtr]. It is combinational, with zero latency from the head pointer.
- Write-to-read latency: a word pushed into an empty FIFO appears on popData one cycle later, with empty=0.
- Ordering is strictly first in, first out. Wrap-around is transparent after any number of cycles.
- Ignored requests (overflow/underflow) never corrupt stored data or pointers.

Optional Feature:
- Macro: FIFO_ERROR_FLAGS_EN.
- When defined, two extra outputs are present:
  - overflow (1 bit): sticky, set at an edge where push=1, full=1 and pop=0;
  - underflow (1 bit): sticky, set at an edge where pop=1 and empty=1.
- Both flags clear only on reset (to 0).
- When the macro is undefined, these ports and their logic are absent. The ignore behaviour for rejected requests is identical in both builds.

Test Plan:
- Reset: hold reset=0 for 2 cycles -> empty=1, full=0, popData=0. Assert reset=0 mid-operation with 5 words stored -> empty=1 immediately, without waiting for a clock edge.
- Fill/drain: push 0x00000001..0x00000010 (16 words) -> full=1 after the 16th push. Then pop 16 times -> popData sequence 1..16 in order; empty=1 after the last pop.
- Overflow: with the FIFO full, push 0xDEADBEEF without pop -> no change; popData still 0x00000001, count 16, overflow=1 if FIFO_ERROR_FLAGS_EN is defined.
- Underflow: pop while empty -> empty stays 1, popData=0, underflow=1 if the macro is defined. Then push 0xA5A5A5A5 -> popData=0xA5A5A5A5 on the next cycle.
- Simultaneous access:
  - push+pop while full with pushData 0x11 -> full stays 1 and the head advances; the 0x11 word emerges 16 pops later;
  - push+pop while empty with 0x22 -> count 1, popData=0x22.
- Wrap-around stress: 1000 cycles of random push/pop with a scoreboard model -> every popped word matches the model, and full/empty exactly track the model's count of 16/0.
